// File: rtl/fp16_add_issuer_if.sv
// Operand-side bundle between the FP16 add issuer and its environment.
// Latency: none, signal container only.
// Backpressure: req and rsp are valid/ready; the adder channels have no tready.
//
// Ports (signals carried):
//   req_*                 tagged operand-pair request, valid/ready
//   m_axis_a/b_*          operand channels toward the adder
//   s_axis_result_*       result channel from the adder
//   rsp_*                 tagged in-order result, valid/ready
//   busy, err_spurious    status
interface fp16_add_issuer_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_a;
  logic [15:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             m_axis_a_tvalid;
  logic [31:0]      m_axis_a_tdata;
  logic             m_axis_b_tvalid;
  logic [31:0]      m_axis_b_tdata;
  logic             s_axis_result_tvalid;
  logic [31:0]      s_axis_result_tdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic             err_spurious;

  // Issuer side
  modport master (
    input  req_valid, req_a, req_b, req_tag,
    input  s_axis_result_tvalid, s_axis_result_tdata, rsp_ready,
    output req_ready, m_axis_a_tvalid, m_axis_a_tdata,
    output m_axis_b_tvalid, m_axis_b_tdata,
    output rsp_valid, rsp_data, rsp_tag, busy, err_spurious
  );

  // Environment side (requester, adder, response sink)
  modport slave (
    output req_valid, req_a, req_b, req_tag,
    output s_axis_result_tvalid, s_axis_result_tdata, rsp_ready,
    input  req_ready, m_axis_a_tvalid, m_axis_a_tdata,
    input  m_axis_b_tvalid, m_axis_b_tdata,
    input  rsp_valid, rsp_data, rsp_tag, busy, err_spurious
  );
endinterface

// File: rtl/fp16_add_issuer.sv
// Credit-based issuer/collector for an FP16 adder that has no tready.
// Latency: accept -> operand valid 1 cycle; adder result -> rsp_valid 1 cycle.
// Backpressure: req_ready drops when DEPTH ops are in flight or buffered; rsp is valid/ready.
//
// Ports:
//   aclk, areset   clock, asynchronous active-high reset
//   bus (master)   req_*, m_axis_a/b_*, s_axis_result_*, rsp_*, busy, err_spurious

// Generic first-word fall-through FIFO: head_o shows the oldest entry while !empty_o.
// Callers guarantee no push when full and no pop when empty.
module fp16_add_issuer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is read out while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
endmodule

module fp16_add_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 aclk,
  input  logic                 areset,
  fp16_add_issuer_if.master    bus
);
  localparam int             CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(DEPTH);

  logic [CW-1:0]      credits_q, credits_d;
  logic               iss_vld_q;
  logic [15:0]        a_q, b_q;
  logic               busy_q;
  logic               err_q;
  logic               accept, rsp_hs, res_take, tag_empty, res_empty;
  logic [TAG_W-1:0]   tag_head;
  logic [16+TAG_W-1:0] res_head;
  logic               unused_hi;

  assign bus.req_ready = (credits_q != '0) && !areset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rsp_hs        = bus.rsp_valid && bus.rsp_ready;
  // A result only counts when a tag is outstanding; otherwise it is spurious.
  assign res_take      = bus.s_axis_result_tvalid && !tag_empty;
  assign unused_hi     = ^bus.s_axis_result_tdata[31:16];

  // One credit per op, held from accept until its response leaves.
  always_comb begin
    credits_d = credits_q;
    if (accept && !rsp_hs)      credits_d = credits_q - CW'(1);
    else if (!accept && rsp_hs) credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      credits_q <= CRED_MAX;
      iss_vld_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      iss_vld_q <= accept;
      if (accept) begin
        a_q <= bus.req_a;
        b_q <= bus.req_b;
      end
      busy_q <= (credits_d != CRED_MAX);
      if (bus.s_axis_result_tvalid && tag_empty) err_q <= 1'b1;
    end
  end

  assign bus.m_axis_a_tvalid = iss_vld_q;
  assign bus.m_axis_b_tvalid = iss_vld_q;
  assign bus.m_axis_a_tdata  = {16'h0, a_q};
  assign bus.m_axis_b_tdata  = {16'h0, b_q};
  assign bus.busy            = busy_q;
  assign bus.err_spurious    = err_q;

  fp16_add_issuer_fifo #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk        (aclk),
    .rst        (areset),
    .push_i     (accept),
    .push_dat_i (bus.req_tag),
    .pop_i      (res_take),
    .head_o     (tag_head),
    .empty_o    (tag_empty)
  );

  fp16_add_issuer_fifo #(.W(16 + TAG_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk        (aclk),
    .rst        (areset),
    .push_i     (res_take),
    .push_dat_i ({bus.s_axis_result_tdata[15:0], tag_head}),
    .pop_i      (rsp_hs),
    .head_o     (res_head),
    .empty_o    (res_empty)
  );

  // Outputs read as zero while empty so stale storage never shows.
  assign bus.rsp_valid = !res_empty;
  assign bus.rsp_data  = res_empty ? 16'h0 : res_head[TAG_W +: 16];
  assign bus.rsp_tag   = res_empty ? '0 : res_head[TAG_W-1:0];
endmodule
